fft_peak_detect: RTL

- Sits directly downstream of fft_512 and consumes its output RAM after each transform.
- On fft_done it scans bins 0..NUM_BINS-1 through the FFT read port and computes the 48-bit magnitude squared of each bin.
- Streams each bin's magnitude for display logic and reports the strongest bin, its magnitude and its frequency in Hz.

---
 rtl/fft_peak_detect.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_peak_detect.sv
// -----------------------------------------------------------------------------
// fft_peak_detect
// Scans the positive-frequency bins of the fft_512 output RAM after each
// transform, streams |X[k]|^2 for every bin and reports the strongest bin,
// its magnitude and its frequency in Hz.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   fft_done           start pulse from fft_512 (ignored while a scan runs)
//   fft_out_addr       bin read address to fft_512 (holds when idle)
//   fft_out_re/_im     signed bin data, READ_LATENCY cycles after the address
//   threshold          minimum peak magnitude for peak_valid
//   busy               scan in progress
//   mag_valid/_bin/_data  one streamed magnitude per bin, in bin order
//   result_valid       one-cycle pulse when the peak results are loaded
//   peak_bin/_mag/_valid/_hz  peak results, held until the next result
// -----------------------------------------------------------------------------
module fft_peak_detect #(
   parameter int NUM_BINS     = 256,
   parameter int READ_LATENCY = 1,
   parameter int SKIP_DC      = 1,
   parameter int BIN_HZ_Q16   = 6000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_done,
   output logic [8:0]         fft_out_addr,
   input  logic signed [23:0] fft_out_re,
   input  logic signed [23:0] fft_out_im,
   input  logic [47:0]        threshold,
   output logic               busy,
   output logic               mag_valid,
   output logic [8:0]         mag_bin,
   output logic [47:0]        mag_data,
   output logic               result_valid,
   output logic [8:0]         peak_bin,
   output logic [47:0]        peak_mag,
   output logic               peak_valid,
   output logic [15:0]        peak_hz
);

   localparam logic [8:0]  LAST_BIN  = 9'(NUM_BINS - 1);
   localparam logic [8:0]  START_BIN = (SKIP_DC != 0) ? 9'd1 : 9'd0;
   localparam logic [31:0] BIN_HZ_W  = 32'(BIN_HZ_Q16);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [8:0]  addr_q, addr_d;
   logic        start_s;
   logic        last_cmp_s;

   // {valid, address} delayed to line up with the returning RAM data
   logic [9:0]  dly_q [READ_LATENCY];

   logic signed [46:0] re_ext_s, im_ext_s;
   logic [46:0] p_re_q, p_im_q;
   logic        s1_valid_q;
   logic [8:0]  s1_bin_q;

   logic        mag_valid_q;
   logic [8:0]  mag_bin_q;
   logic [47:0] mag_data_q;

   logic [47:0] max_mag_q, max_mag_d;
   logic [8:0]  max_bin_q, max_bin_d;

   logic        busy_q, result_valid_q, peak_valid_q;
   logic [8:0]  peak_bin_q;
   logic [47:0] peak_mag_q;
   logic [15:0] peak_hz_q, peak_hz_s;

   // Sign-extend before squaring so the 47-bit product is exact.
   assign re_ext_s = 47'(fft_out_re);
   assign im_ext_s = 47'(fft_out_im);

   // The last compare is the cycle the final bin's magnitude is on the stream.
   assign last_cmp_s = mag_valid_q && (mag_bin_q == LAST_BIN);

   // Next-state and address sequencing.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (fft_done) begin
               state_d = SCAN;
               addr_d  = 9'd0;
               start_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN: begin
            if (addr_q == LAST_BIN) begin
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + 9'd1;
            end
         end
         DRAIN: begin
            if (last_cmp_s) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Running maximum; strict compare keeps the lowest bin on ties.
   always_comb begin
      max_mag_d = max_mag_q;
      max_bin_d = max_bin_q;
      if (start_s) begin
         max_mag_d = 48'd0;
         max_bin_d = START_BIN;
      end else if (mag_valid_q && (mag_data_q > max_mag_q) &&
                   !((SKIP_DC != 0) && (mag_bin_q == 9'd0))) begin
         max_mag_d = mag_data_q;
         max_bin_d = mag_bin_q;
      end else begin
         max_mag_d = max_mag_q;
         max_bin_d = max_bin_q;
      end
   end

   // Bin spacing is Q16.16, so the integer Hz is the product's upper half.
   assign peak_hz_s = 16'((32'(max_bin_d) * BIN_HZ_W) >> 16);

   // State, address and read-address delay line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 9'd0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            dly_q[k] <= 10'd0;
         end
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         dly_q[0] <= {(state_q == SCAN), addr_q};
         for (int k = 1; k < READ_LATENCY; k++) begin
            dly_q[k] <= dly_q[k-1];
         end
      end
   end

   // Two-stage magnitude pipeline: square, then sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_re_q      <= 47'd0;
         p_im_q      <= 47'd0;
         s1_valid_q  <= 1'b0;
         s1_bin_q    <= 9'd0;
         mag_valid_q <= 1'b0;
         mag_bin_q   <= 9'd0;
         mag_data_q  <= 48'd0;
      end else begin
         p_re_q      <= re_ext_s * re_ext_s;
         p_im_q      <= im_ext_s * im_ext_s;
         s1_valid_q  <= dly_q[READ_LATENCY-1][9];
         s1_bin_q    <= dly_q[READ_LATENCY-1][8:0];
         mag_valid_q <= s1_valid_q;
         mag_bin_q   <= s1_bin_q;
         mag_data_q  <= {1'b0, p_re_q} + {1'b0, p_im_q};
      end
   end

   // Peak tracking, status flags and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_mag_q      <= 48'd0;
         max_bin_q      <= 9'd0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         peak_bin_q     <= 9'd0;
         peak_mag_q     <= 48'd0;
         peak_valid_q   <= 1'b0;
         peak_hz_q      <= 16'd0;
      end else begin
         max_mag_q      <= max_mag_d;
         max_bin_q      <= max_bin_d;
         busy_q         <= (state_d == SCAN) || (state_d == DRAIN);
         result_valid_q <= (state_d == DONE);
         if (last_cmp_s) begin
            peak_bin_q   <= max_bin_d;
            peak_mag_q   <= max_mag_d;
            peak_valid_q <= (max_mag_d >= threshold);
            peak_hz_q    <= peak_hz_s;
         end else begin
            peak_bin_q   <= peak_bin_q;
            peak_mag_q   <= peak_mag_q;
            peak_valid_q <= peak_valid_q;
            peak_hz_q    <= peak_hz_q;
         end
      end
   end

   assign fft_out_addr = addr_q;
   assign busy         = busy_q;
   assign mag_valid    = mag_valid_q;
   assign mag_bin      = mag_bin_q;
   assign mag_data     = mag_data_q;
   assign result_valid = result_valid_q;
   assign peak_bin     = peak_bin_q;
   assign peak_mag     = peak_mag_q;
   assign peak_valid   = peak_valid_q;
   assign peak_hz      = peak_hz_q;

endmodule
